// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs. load) with a per-register pending-write scoreboard.
// Define RF_ARB_FIXED_PRIO_EN to make the load source always win on contention.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              rf_wr,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd,
   input  logic              sb_set,
   input  logic [ADDR_W-1:0] sb_addr,
   output logic              sb_ready,
   input  logic [ADDR_W-1:0] chk_a1,
   input  logic [ADDR_W-1:0] chk_a2,
   output logic              hazard,
   input  logic              flush
);

   localparam int NREG = 2 ** ADDR_W;

   // Handshake: a source is accepted in any cycle where its valid and ready are
   // both high. ready is combinational from both valids, the priority state and
   // flush, so a source must not wait for ready before raising valid.

   logic              acc;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_data;
   logic              set_en;
   logic              dec_en;
   logic [NREG-1:0]   inc_vec;
   logic [NREG-1:0]   dec_vec;
   logic [1:0]        cnt_q [NREG];
   logic [1:0]        cnt_d [NREG];

`ifdef RF_ARB_FIXED_PRIO_EN
   assign ld_ready  = ld_valid & ~flush;
   assign alu_ready = alu_valid & ~ld_valid & ~flush;
`else
   logic ptr_q;

   // ptr_q = 0 favours ALU; it flips only when both sources contend
   assign alu_ready = alu_valid & (~ld_valid | ~ptr_q) & ~flush;
   assign ld_ready  = ld_valid & (~alu_valid | ptr_q) & ~flush;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= 1'b0;
      end else if (alu_valid && ld_valid && !flush) begin
         ptr_q <= ~ptr_q;
      end
   end
`endif

   assign acc      = alu_ready | ld_ready;
   assign acc_addr = alu_ready ? alu_addr : ld_addr;
   assign acc_data = alu_ready ? alu_data : ld_data;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rf_wr <= 1'b0;
         rf_a3 <= '0;
         rf_wd <= '0;
      end else begin
         rf_wr <= acc & (acc_addr != '0);
         if (acc) begin
            rf_a3 <= acc_addr;
            rf_wd <= acc_data;
         end
      end
   end

   assign sb_ready = (cnt_q[sb_addr] != 2'd3) | (sb_addr == '0);
   assign set_en   = sb_set & sb_ready & (sb_addr != '0) & ~flush;
   assign dec_en   = acc & (acc_addr != '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (set_en) inc_vec[sb_addr] = 1'b1;
      if (dec_en) dec_vec[acc_addr] = 1'b1;
   end

   // A set and a retire on the same register cancel; retire saturates at zero
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (flush) begin
            cnt_d[r] = 2'd0;
         end else if (inc_vec[r] && !dec_vec[r]) begin
            cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (dec_vec[r] && !inc_vec[r] && cnt_q[r] != 2'd0) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
      cnt_d[0] = 2'd0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   assign hazard = ((chk_a1 != '0) & (cnt_q[chk_a1] != 2'd0)) |
                   ((chk_a2 != '0) & (cnt_q[chk_a2] != 2'd0));

endmodule
